fix_checksum_check: RTL and testbench

- Receive-side counterpart of the checksum generator.
- Consumes a FIX message byte stream and sums every byte modulo 256 up to and including the SOH that precedes the "10=" trailer tag.
- Parses the three ASCII checksum digits, requires a terminating SOH, then reports pass/fail with the computed and received values.
- Sits between the byte deframer and the field parser; the parser discards messages on fail.

---
 rtl/fix_pkg.sv | 41 ++++
 rtl/fix_trailer_match.sv | 39 +++
 rtl/fix_checksum_check.sv | 206 ++++++++++++++++++++
 tb/tb_fix_checksum_check.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared FIX definitions: delimiter/ASCII constants, checker state encoding,
// result record and small decimal-digit helpers.
package fix_pkg;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam int         MAX_LEN_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BODY   = 3'd1,
        DIGITS = 3'd2,
        TERM   = 3'd3,
        DRAIN  = 3'd4,
        REPORT = 3'd5
    } chk_state_t;

    typedef struct packed {
        logic       pass;
        logic       fmt_err;
        logic [7:0] computed;
        logic [9:0] received;
    } chk_result_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // Appends one ASCII decimal digit to a running 10-bit value.
    function automatic logic [9:0] dec_append(input logic [9:0] acc, input logic [7:0] b);
        logic [7:0] d;
        logic [9:0] t;
        d = b - ASCII_0;
        t = acc * 10'd10;
        return t + {6'd0, d[3:0]};
    endfunction

endpackage

// File: rtl/fix_trailer_match.sv
// Four-byte sliding window that flags SOH,'1','0','=' with '=' as the current byte.
module fix_trailer_match
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       tag_hit_o
);

    logic [23:0] win_q;
    logic [23:0] win_d;

    // Next window: a message start discards older bytes so tags never span messages.
    always_comb begin
        win_d = win_q;
        if (load_i) begin
            win_d = {16'h0000, data_i};
        end else if (shift_i) begin
            win_d = {win_q[15:0], data_i};
        end else begin
            win_d = win_q;
        end
    end

    // Window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= 24'h000000;
        end else begin
            win_q <= win_d;
        end
    end

    assign tag_hit_o = ({win_q, data_i} == {SOH, ASCII_1, ASCII_0, ASCII_EQ});

endmodule

// File: rtl/fix_checksum_check.sv
// Receive-side FIX checksum checker: sums bytes through the SOH before "10=",
// parses the three trailer digits and reports pass/format-error one cycle after end_i.
module fix_checksum_check
    import fix_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       start_i,
    input  logic       end_i,
    output logic       done_o,
    output logic       pass_o,
    output logic       fmt_err_o,
    output logic [7:0] computed_o,
    output logic [9:0] received_o,
    output logic       busy_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    chk_state_t       state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [1:0][7:0]  hist_q, hist_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [9:0]       recv_q, recv_d;
    logic [7:0]       ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    chk_result_t      res_q, res_d;
    logic             fin_s, fin_pass_s, fin_err_s, tag_hit_s;

    fix_trailer_match u_match (
        .clk       (clk),
        .rst       (rst),
        .load_i    (valid_i & start_i),
        .shift_i   (valid_i & (state_q == BODY)),
        .data_i    (data_i),
        .tag_hit_o (tag_hit_s)
    );

    // Message FSM, accumulation and result formation.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        hist_d     = hist_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        recv_d     = recv_q;
        ref_d      = ref_q;
        ref_vld_d  = ref_vld_q;
        fin_s      = 1'b0;
        fin_pass_s = 1'b0;
        fin_err_s  = 1'b0;
        res_d      = '{pass: 1'b0, fmt_err: 1'b0, computed: res_q.computed, received: res_q.received};

        if (valid_i && start_i) begin
            state_d   = BODY;
            sum_d     = data_i;
            hist_d    = {8'h00, 8'h00};
            len_d     = LEN_W'(1);
            cnt_d     = 2'd0;
            recv_d    = 10'd0;
            ref_d     = 8'h00;
            ref_vld_d = 1'b0;
            fin_s     = end_i;
            fin_err_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                BODY: begin
                    if (valid_i) begin
                        sum_d  = sum_q + data_i;
                        hist_d = {hist_q[0], sum_q};
                        len_d  = len_q + LEN_W'(1);
                        if (end_i) begin
                            fin_s     = 1'b1;
                            fin_err_s = 1'b1;
                        end else if (tag_hit_s) begin
                            // History slot 1 is the sum before the '1', i.e. through the SOH.
                            ref_d     = hist_q[1];
                            ref_vld_d = 1'b1;
                            cnt_d     = 2'd0;
                            recv_d    = 10'd0;
                            state_d   = DIGITS;
                        end else if (len_d == LEN_W'(MAX_LEN)) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = BODY;
                        end
                    end else begin
                        state_d = BODY;
                    end
                end
                DIGITS: begin
                    if (valid_i) begin
                        sum_d = sum_q + data_i;
                        if (is_digit(data_i)) begin
                            recv_d = dec_append(recv_q, data_i);
                            cnt_d  = cnt_q + 2'd1;
                            if (end_i) begin
                                fin_s     = 1'b1;
                                fin_err_s = 1'b1;
                            end else if (cnt_q == 2'd2) begin
                                state_d = TERM;
                            end else begin
                                state_d = DIGITS;
                            end
                        end else if (end_i) begin
                            fin_s     = 1'b1;
                            fin_err_s = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = DIGITS;
                    end
                end
                TERM: begin
                    if (valid_i) begin
                        sum_d = sum_q + data_i;
                        if (end_i) begin
                            fin_s      = 1'b1;
                            fin_err_s  = (data_i != SOH);
                            fin_pass_s = (data_i == SOH) && (recv_q == {2'b00, ref_q});
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = TERM;
                    end
                end
                DRAIN: begin
                    if (valid_i && end_i) begin
                        fin_s     = 1'b1;
                        fin_err_s = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                REPORT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (fin_s) begin
            state_d = REPORT;
            res_d   = '{pass:     fin_pass_s,
                        fmt_err:  fin_err_s,
                        computed: ref_vld_d ? ref_d : sum_d,
                        received: recv_d};
        end else begin
            res_d.pass    = 1'b0;
            res_d.fmt_err = 1'b0;
        end
        done_d = fin_s;
        busy_d = (state_d == BODY) || (state_d == DIGITS) || (state_d == TERM) || (state_d == DRAIN);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sum_q     <= 8'h00;
            hist_q    <= {8'h00, 8'h00};
            len_q     <= '0;
            cnt_q     <= 2'd0;
            recv_q    <= 10'd0;
            ref_q     <= 8'h00;
            ref_vld_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            hist_q    <= hist_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            recv_q    <= recv_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            res_q     <= res_d;
        end
    end

    assign done_o     = done_q;
    assign pass_o     = res_q.pass;
    assign fmt_err_o  = res_q.fmt_err;
    assign computed_o = res_q.computed;
    assign received_o = res_q.received;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_fix_checksum_check.sv
// Scoreboard bench for fix_checksum_check: directed messages push hand-computed
// results; a negedge monitor pops and compares on every done_o.
module tb_fix_checksum_check;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       start_i;
    logic       end_i;
    logic       done_o;
    logic       pass_o;
    logic       fmt_err_o;
    logic [7:0] computed_o;
    logic [9:0] received_o;
    logic       busy_o;

    fix_checksum_check dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .start_i    (start_i),
        .end_i      (end_i),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .fmt_err_o  (fmt_err_o),
        .computed_o (computed_o),
        .received_o (received_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic       pass;
        logic       fmt_err;
        logic [7:0] comp;
        logic [9:0] recv;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // '|' in a message string stands for SOH.
    task automatic send(input string s, input bit gaps, input bit with_end,
                        input logic p, input logic e, input logic [7:0] c, input logic [9:0] r);
        exp_t x;
        for (int i = 0; i < s.len(); i++) begin
            valid_i = 1'b1;
            data_i  = (s[i] == 8'h7C) ? 8'h01 : s[i];
            start_i = (i == 0);
            end_i   = with_end && (i == s.len() - 1);
            @(posedge clk);
            if (end_i) begin
                x.pass = p; x.fmt_err = e; x.comp = c; x.recv = r; x.due = cyc + 1;
                sb.push_back(x);
            end
            #1;
            valid_i = 1'b0;
            start_i = 1'b0;
            end_i   = 1'b0;
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: compares each reported result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done_o) begin
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no report", cyc);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (cyc != e.due || pass_o !== e.pass || fmt_err_o !== e.fmt_err ||
                    computed_o !== e.comp || received_o !== e.recv) begin
                    fails++;
                    $display("FAIL report: got cyc=%0d pass=%0b err=%0b comp=%0d recv=%0d expected cyc=%0d pass=%0b err=%0b comp=%0d recv=%0d",
                             cyc, pass_o, fmt_err_o, computed_o, received_o,
                             e.due, e.pass, e.fmt_err, e.comp, e.recv);
                end
            end
        end else if (pass_o || fmt_err_o) begin
            fails++;
            $display("FAIL flags_idle: got pass=%0b err=%0b expected 0 0 outside done", pass_o, fmt_err_o);
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; start_i = 1'b0; end_i = 1'b0; data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_err", fmt_err_o, 0);
        chk("rst_comp", computed_o, 0);
        chk("rst_recv", received_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send("8=A|10=183|",   1'b0, 1'b1, 1'b1, 1'b0, 8'd183, 10'd183);
        send("8=ABC|10=060|", 1'b0, 1'b1, 1'b1, 1'b0, 8'd60,  10'd60);
        send("8=A|10=184|",   1'b0, 1'b1, 1'b0, 1'b0, 8'd183, 10'd184);
        send("8=A|10=1X3|",   1'b0, 1'b1, 1'b0, 1'b1, 8'd183, 10'd1);
        send("8=A|10=439|",   1'b0, 1'b1, 1'b0, 1'b0, 8'd183, 10'd439);
        send("8=A|10=183|",   1'b1, 1'b1, 1'b1, 1'b0, 8'd183, 10'd183);
        send("Z",             1'b0, 1'b1, 1'b0, 1'b1, 8'd90,  10'd0);
        send("8=A|110=183|",  1'b0, 1'b1, 1'b0, 1'b1, 8'd35,  10'd0);
        send("8=A|10",        1'b0, 1'b1, 1'b0, 1'b1, 8'd24,  10'd0);

        // Restart mid-message: only the second message reports.
        send("8=B|1",         1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   10'd0);
        chk("busy_mid", busy_o, 1);
        send("8=A|10=183|",   1'b0, 1'b1, 1'b1, 1'b0, 8'd183, 10'd183);

        // Reset mid-message abandons it silently.
        send("8=A|10=1",      1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   10'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("busy_after_rst", busy_o, 0);
        send("8=A|10=183|",   1'b0, 1'b1, 1'b1, 1'b0, 8'd183, 10'd183);

        // Length limit: 4096 'A' bytes sum to 0 mod 256, rest drained.
        for (int i = 0; i < 4100; i++) begin
            exp_t x;
            valid_i = 1'b1;
            data_i  = 8'h41;
            start_i = (i == 0);
            end_i   = (i == 4099);
            @(posedge clk);
            if (end_i) begin
                x.pass = 1'b0; x.fmt_err = 1'b1; x.comp = 8'd0; x.recv = 10'd0; x.due = cyc + 1;
                sb.push_back(x);
            end
            #1;
        end
        valid_i = 1'b0; start_i = 1'b0; end_i = 1'b0;

        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reports_outstanding", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
